sc_multi_charge_ctrl: RTL
=========================

SC_MULTI_CHARGE_CTRL -- requirements
Module: sc_multi_charge_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of charging channels (1..16).
REQ-002 SHALL have parameter WAIT_CYC, default 1000: back-off cycles in WAIT before re-checking the grid.
REQ-003 SHALL have parameter RELAY_DLY, default 16: cycles between relay close and charge enable.
REQ-004 SHALL have parameter MAX_ACT_NORMAL, default N_CH: active-channel cap when the grid is NORMAL.
REQ-005 SHALL have parameter MAX_ACT_UNSTABLE, default 1: active-channel cap when the grid is UNSTABLE.
REQ-006 SHALL have ports as follows; reset reset_n is asynchronous, active-low; clock clk.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- grid_state  in  grid_state_t  NORMAL/UNSTABLE/CRITICAL from the grid classifier
- battery_connected  in  N_CH  per-channel battery present
- battery_full  in  N_CH  per-channel battery full
- fault_flag  in  N_CH  per-channel safety fault, level
- fault_clr  in  N_CH  per-channel fault acknowledge, 1-cycle pulse
- relay_activation  out  N_CH  per-channel relay drive
- charge_enable  out  N_CH  per-channel charger enable
- ch_state  out  3*N_CH  per-channel state_t, channel i at bits [3i+2:3i]
- active_count  out  $clog2(N_CH+1)  number of channels in RELAY_ON or CHARGING
- fault_any  out  1  OR of all channels in FAULT

Function
REQ-007 Each channel SHALL run an independent FSM with the states IDLE, CHECK_GRID, WAIT, RELAY_ON, CHARGING and FAULT.
REQ-008 Transition priority per channel SHALL be: fault_flag, then grid CRITICAL, then disconnect/full, then shed, then the normal transitions.
REQ-009 fault_flag[i]=1 in any state SHALL move channel i to FAULT on the next edge.
REQ-010 In IDLE, connected && !full SHALL move the channel to CHECK_GRID.
REQ-011 In CHECK_GRID, grid CRITICAL SHALL move the channel to FAULT, a grant SHALL move it to RELAY_ON, and otherwise it SHALL move to WAIT.
REQ-012 In CHECK_GRID or WAIT, !connected or full SHALL move the channel to IDLE.
REQ-013 WAIT SHALL use a per-channel counter that increments each cycle while grid != CRITICAL, clears while CRITICAL, and moves the channel to CHECK_GRID at count WAIT_CYC-1; CRITICAL in WAIT SHALL NOT fault the channel because its relay is open.
REQ-014 RELAY_ON SHALL hold for exactly RELAY_DLY cycles, then move to CHARGING; CRITICAL during RELAY_ON SHALL move to FAULT; disconnect during RELAY_ON SHALL move to IDLE.
REQ-015 In CHARGING, full or !connected SHALL move to IDLE, CRITICAL SHALL move to FAULT, and a shed SHALL move to WAIT with the WAIT counter cleared.
REQ-016 FAULT SHALL exit to IDLE only on fault_clr[i]=1 with fault_flag[i]=0; a fault_clr while fault_flag=1 SHALL be ignored.
REQ-017 Outputs SHALL be Moore-decoded from registered state: relay_activation=1 in RELAY_ON and CHARGING, charge_enable=1 in CHARGING only, 0 elsewhere.
REQ-018 cap SHALL equal MAX_ACT_NORMAL when NORMAL, MAX_ACT_UNSTABLE when UNSTABLE, and 0 when CRITICAL.
REQ-019 The arbiter SHALL issue at most one grant per cycle, only when active_count < cap, round-robin over CHECK_GRID channels, starting after the last granted index.
REQ-020 When active_count > cap and the grid is not CRITICAL, exactly one shed per cycle SHALL go to the highest-index CHARGING channel; a RELAY_ON channel SHALL be shed only if no channel is CHARGING.
REQ-021 A grant and a shed SHALL never occur in the same cycle.
REQ-022 active_count and fault_any SHALL be registered, consistent with ch_state in the same cycle.
REQ-023 Latency SHALL be one clock from an input event to the state/output change.

Reset
REQ-024 Asserting reset_n low SHALL asynchronously set all channels to IDLE, clear all counters, reset the round-robin pointer to channel 0, and drive relay_activation=0, charge_enable=0, active_count=0, fault_any=0, including mid-charge.

Structure
REQ-025 grid_state_t, state_t (3-bit: IDLE=0, CHECK_GRID=1, WAIT=2, RELAY_ON=3, CHARGING=4, FAULT=5) and the default timing constants SHALL live in the shared package sc_pkg.
REQ-026 The per-channel FSM and counters SHALL be sub-module sc_charge_channel, instantiated N_CH times; arbiter, shed logic and active count SHALL be in the top level.

Verification
REQ-027 Test: N_CH=4, NORMAL, all connected at t0 -> grants to ch0..ch3 on consecutive cycles; charge_enable[i] rises RELAY_DLY cycles after relay_activation[i].
REQ-028 Test: 4 channels CHARGING, grid -> UNSTABLE -> ch3, ch2, ch1 shed on 3 consecutive cycles; ch0 keeps charging; active_count=1.
REQ-029 Test: ch1 CHARGING, grid -> CRITICAL -> ch1 in FAULT next cycle with relay 0; fault_clr with fault_flag=0 -> IDLE.
REQ-030 Test: fault_flag[2]=1 and fault_clr[2]=1 held together -> ch2 stays in FAULT; fault_clr after fault_flag drops -> IDLE.
REQ-031 Test: WAIT_CYC=8, ch0 in WAIT, CRITICAL pulse at count 5 -> counter clears; CHECK_GRID reached 8 non-critical cycles later.
REQ-032 Test: reset_n low during RELAY_ON -> relay_activation drops asynchronously; all ch_state=IDLE.

Source files
------------

// File: rtl/sc_pkg.sv
// sc_pkg: shared types and default timing for the multi-channel charge controller
package sc_pkg;

    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2
    } grid_state_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK_GRID = 3'd1,
        ST_WAIT       = 3'd2,
        ST_RELAY_ON   = 3'd3,
        ST_CHARGING   = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    localparam int DEF_WAIT_CYC  = 1000;
    localparam int DEF_RELAY_DLY = 16;

endpackage

// File: rtl/sc_charge_channel.sv
// sc_charge_channel: one charging channel FSM with back-off and relay-settle counters
module sc_charge_channel
    import sc_pkg::*;
#(
    parameter int WAIT_CYC  = DEF_WAIT_CYC,
    parameter int RELAY_DLY = DEF_RELAY_DLY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  grid_state_t grid_state,
    input  logic        connected,
    input  logic        full,
    input  logic        fault_flag,
    input  logic        fault_clr,
    input  logic        grant,
    input  logic        room,
    input  logic        shed,
    output state_t      state,
    output state_t      state_next,
    output logic        relay,
    output logic        charge_en
);

    localparam int WW = $clog2(WAIT_CYC > 1 ? WAIT_CYC : 2);
    localparam int RW = $clog2(RELAY_DLY > 1 ? RELAY_DLY : 2);

    logic [WW-1:0] wait_cnt, wait_cnt_next;
    logic [RW-1:0] rly_cnt, rly_cnt_next;
    logic          crit, gone;

    assign crit      = grid_state == GRID_CRITICAL;
    assign gone      = !connected || full;
    assign relay     = state == ST_RELAY_ON || state == ST_CHARGING;
    assign charge_en = state == ST_CHARGING;

    // state and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            rly_cnt  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            rly_cnt  <= rly_cnt_next;
        end
    end

    // next state; counters run only while in their own state and restart on entry
    // a CHECK_GRID channel that lost arbitration while capacity remains keeps
    // waiting for its turn instead of backing off
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        rly_cnt_next  = '0;
        if (fault_flag) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: if (connected && !full) state_next = ST_CHECK_GRID;
                ST_CHECK_GRID: begin
                    if (crit) state_next = ST_FAULT;
                    else if (gone) state_next = ST_IDLE;
                    else if (grant) state_next = ST_RELAY_ON;
                    else if (!room) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (gone) state_next = ST_IDLE;
                    else if (crit) wait_cnt_next = '0;
                    else if (wait_cnt == WW'(WAIT_CYC - 1)) state_next = ST_CHECK_GRID;
                    else wait_cnt_next = wait_cnt + 1'b1;
                end
                ST_RELAY_ON: begin
                    if (crit) state_next = ST_FAULT;
                    else if (!connected) state_next = ST_IDLE;
                    else if (shed) state_next = ST_WAIT;
                    else if (rly_cnt == RW'(RELAY_DLY - 1)) state_next = ST_CHARGING;
                    else rly_cnt_next = rly_cnt + 1'b1;
                end
                ST_CHARGING: begin
                    if (crit) state_next = ST_FAULT;
                    else if (gone) state_next = ST_IDLE;
                    else if (shed) state_next = ST_WAIT;
                end
                ST_FAULT: if (fault_clr) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sc_multi_charge_ctrl.sv
// sc_multi_charge_ctrl: N-channel charge controller with grid-aware admission and load shedding
module sc_multi_charge_ctrl
    import sc_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int WAIT_CYC         = DEF_WAIT_CYC,
    parameter int RELAY_DLY        = DEF_RELAY_DLY,
    parameter int MAX_ACT_NORMAL   = N_CH,
    parameter int MAX_ACT_UNSTABLE = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  grid_state_t               grid_state,
    input  logic [N_CH-1:0]           battery_connected,
    input  logic [N_CH-1:0]           battery_full,
    input  logic [N_CH-1:0]           fault_flag,
    input  logic [N_CH-1:0]           fault_clr,
    output logic [N_CH-1:0]           relay_activation,
    output logic [N_CH-1:0]           charge_enable,
    output logic [3*N_CH-1:0]         ch_state,
    output logic [$clog2(N_CH+1)-1:0] active_count,
    output logic                      fault_any
);

    localparam int CW = $clog2(N_CH + 1);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t          st      [N_CH];
    state_t          st_next [N_CH];
    logic [N_CH-1:0] grant, shed, chg_sel, rly_sel;
    logic [CW-1:0]   cap, cnt_next;
    logic [PW-1:0]   rr_ptr, rr_ptr_next, idx;
    logic            can_grant, do_shed, found, fault_next;

    assign cap = grid_state == GRID_NORMAL   ? CW'(MAX_ACT_NORMAL) :
                 grid_state == GRID_UNSTABLE ? CW'(MAX_ACT_UNSTABLE) : '0;
    assign can_grant = active_count < cap;
    assign do_shed   = active_count > cap && grid_state != GRID_CRITICAL;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sc_charge_channel #(
            .WAIT_CYC (WAIT_CYC),
            .RELAY_DLY(RELAY_DLY)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .grid_state(grid_state),
            .connected (battery_connected[i]),
            .full      (battery_full[i]),
            .fault_flag(fault_flag[i]),
            .fault_clr (fault_clr[i]),
            .grant     (grant[i]),
            .room      (can_grant),
            .shed      (shed[i]),
            .state     (st[i]),
            .state_next(st_next[i]),
            .relay     (relay_activation[i]),
            .charge_en (charge_enable[i])
        );
        assign ch_state[3*i +: 3] = st[i];
    end

    // round-robin grant: first CHECK_GRID channel at or after the pointer
    always_comb begin
        grant       = '0;
        rr_ptr_next = rr_ptr;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N_CH);
            if (can_grant && !found && st[idx] == ST_CHECK_GRID) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                rr_ptr_next = PW'((int'(rr_ptr) + k + 1) % N_CH);
            end
        end
    end

    // shed the highest-index charging channel, else the highest-index relay-settling one
    always_comb begin
        chg_sel = '0;
        rly_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (st[i] == ST_CHARGING) begin
                chg_sel    = '0;
                chg_sel[i] = 1'b1;
            end
            if (st[i] == ST_RELAY_ON) begin
                rly_sel    = '0;
                rly_sel[i] = 1'b1;
            end
        end
        shed = !do_shed ? '0 : (|chg_sel ? chg_sel : rly_sel);
    end

    // summary counts from next state so the registered values line up with ch_state
    always_comb begin
        cnt_next   = '0;
        fault_next = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_next   = cnt_next + CW'(st_next[i] == ST_RELAY_ON || st_next[i] == ST_CHARGING);
            fault_next = fault_next | (st_next[i] == ST_FAULT);
        end
    end

    // pointer and summary registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= '0;
            active_count <= '0;
            fault_any    <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_next;
            active_count <= cnt_next;
            fault_any    <= fault_next;
        end
    end

endmodule
